// File: rtl/dmi_cdc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmi_cdc_sequencer                                            |
// | Description : Moves DMI requests from the TCK domain into the core clock   |
// |               domain over a four-phase req/ack level handshake.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmi_cdc_sequencer #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [1:0]        req_op_a,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [DATA_W-1:0] req_data_a,
  output logic              ack_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [1:0]        rsp_status_o,
  output logic              tgt_valid,
  input  logic              tgt_ready,
  output logic              tgt_write,
  output logic [ADDR_W-1:0] tgt_addr,
  output logic [DATA_W-1:0] tgt_wdata,
  input  logic              tgt_rsp_valid,
  input  logic [DATA_W-1:0] tgt_rsp_data,
  input  logic              tgt_rsp_err,
  output logic              tgt_abort,
  output logic              busy,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_ACK      = 2'd3
  } state_t;

  localparam logic [1:0]  c_OP_NOP     = 2'd0;
  localparam logic [1:0]  c_OP_READ    = 2'd1;
  localparam logic [1:0]  c_OP_WRITE   = 2'd2;
  localparam logic [1:0]  c_ST_OK      = 2'd0;
  localparam logic [1:0]  c_ST_FAIL    = 2'd2;
  localparam logic [1:0]  c_ST_TIMEOUT = 2'd3;
  localparam logic [15:0] c_TMO_LAST   = 16'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_req_s;
  logic                   w_tmo;
  state_t                 r_state;
  logic [15:0]            r_cnt;
  logic                   r_ack;
  logic [DATA_W-1:0]      r_rsp_data;
  logic [1:0]             r_rsp_status;
  logic                   r_valid;
  logic                   r_write;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic                   r_abort;
  logic                   r_busy;
  logic                   r_proto;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_a};
    end
  end

  assign w_req_s = r_sync[SYNC_STAGES-1];
  // >= so a handshake landing on the last counted edge still times out in WAIT_RSP
  assign w_tmo   = (r_cnt >= c_TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ack        <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= c_ST_OK;
      r_valid      <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_abort      <= 1'b0;
      r_busy       <= 1'b0;
      r_proto      <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_s) begin
            r_busy <= 1'b1;
            if (req_op_a == c_OP_READ || req_op_a == c_OP_WRITE) begin
              // Payload is quasi-static while req is high, so sample it once here
              r_addr  <= req_addr_a;
              r_wdata <= req_data_a;
              r_write <= (req_op_a == c_OP_WRITE);
              r_cnt   <= '0;
              r_valid <= 1'b1;
              r_state <= ST_ISSUE;
            end else begin
              r_rsp_status <= (req_op_a == c_OP_NOP) ? c_ST_OK : c_ST_FAIL;
              r_ack        <= 1'b1;
              r_state      <= ST_ACK;
            end
          end
        end
        ST_ISSUE, ST_WAIT_RSP: begin
          r_cnt <= r_cnt + 16'd1;
          if (!w_req_s) begin
            r_proto <= 1'b1;
          end
          if (r_state == ST_ISSUE && tgt_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_WAIT_RSP;
          end else if (r_state == ST_WAIT_RSP && tgt_rsp_valid) begin
            r_rsp_data   <= r_write ? r_wdata : tgt_rsp_data;
            r_rsp_status <= tgt_rsp_err ? c_ST_FAIL : c_ST_OK;
            r_ack        <= 1'b1;
            r_state      <= ST_ACK;
          end else if (w_tmo) begin
            r_valid      <= 1'b0;
            r_abort      <= 1'b1;
            r_rsp_data   <= '0;
            r_rsp_status <= c_ST_TIMEOUT;
            r_ack        <= 1'b1;
            r_state      <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!w_req_s) begin
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_o        = r_ack;
  assign rsp_data_o   = r_rsp_data;
  assign rsp_status_o = r_rsp_status;
  assign tgt_valid    = r_valid;
  assign tgt_write    = r_write;
  assign tgt_addr     = r_addr;
  assign tgt_wdata    = r_wdata;
  assign tgt_abort    = r_abort;
  assign busy         = r_busy;
  assign proto_err    = r_proto;

endmodule
`default_nettype wire

// File: tb/tb_dmi_cdc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dmi_cdc_sequencer                                         |
// | Description : Self-checking bench with a reactive debug-module model.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dmi_cdc_sequencer;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int S      = 2;
  localparam int T      = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_a;
  logic [1:0]        req_op_a;
  logic [ADDR_W-1:0] req_addr_a;
  logic [DATA_W-1:0] req_data_a;
  logic              ack_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic [1:0]        rsp_status_o;
  logic              tgt_valid;
  logic              tgt_ready;
  logic              tgt_write;
  logic [ADDR_W-1:0] tgt_addr;
  logic [DATA_W-1:0] tgt_wdata;
  logic              tgt_rsp_valid;
  logic [DATA_W-1:0] tgt_rsp_data;
  logic              tgt_rsp_err;
  logic              tgt_abort;
  logic              busy;
  logic              proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: last delivered response data and the sticky violation flag
  logic [DATA_W-1:0] m_rsp_data = '0;
  logic              m_proto    = 1'b0;

  always #5 clk = ~clk;

  dmi_cdc_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(S), .TIMEOUT(T)
  ) u_dut (
    .clk(clk), .reset(reset), .req_a(req_a), .req_op_a(req_op_a),
    .req_addr_a(req_addr_a), .req_data_a(req_data_a), .ack_o(ack_o),
    .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o), .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready), .tgt_write(tgt_write), .tgt_addr(tgt_addr),
    .tgt_wdata(tgt_wdata), .tgt_rsp_valid(tgt_rsp_valid), .tgt_rsp_data(tgt_rsp_data),
    .tgt_rsp_err(tgt_rsp_err), .tgt_abort(tgt_abort), .busy(busy), .proto_err(proto_err)
  );

  task automatic idle_target();
    tgt_ready     = 1'b0;
    tgt_rsp_valid = 1'b0;
    tgt_rsp_err   = 1'b0;
    tgt_rsp_data  = '0;
  endtask

  // One complete request: dr = cycles tgt_valid waits before ready, ds = cycles from
  // handshake to response, drop_n = cycle index at which req_a is pulled early (-1 = never).
  task automatic run_txn(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int dr, input int ds,
                         input logic err, input logic [DATA_W-1:0] rdata,
                         input bit spur, input int drop_n, input string tag);
    bit                is_rw;
    bit                exp_tmo;
    int                c;
    logic [1:0]        exp_st;
    logic [DATA_W-1:0] exp_d;
    int                lat;
    int                n;
    int                vcount;
    int                aborts;
    int                rel;

    is_rw   = (op == 2'd1) || (op == 2'd2);
    exp_tmo = is_rw && (1 + dr + ds > T);
    c       = exp_tmo ? T : 1 + dr + ds;
    if (!is_rw) begin
      exp_st = (op == 2'd0) ? 2'd0 : 2'd2;
      exp_d  = m_rsp_data;
    end else if (exp_tmo) begin
      exp_st = 2'd3;
      exp_d  = '0;
    end else begin
      exp_st = err ? 2'd2 : 2'd0;
      exp_d  = (op == 2'd1) ? rdata : wdata;
    end
    if (is_rw && drop_n >= 0 && drop_n + 1 + S <= c) m_proto = 1'b1;

    @(negedge clk);
    req_a = 1'b1; req_op_a = op; req_addr_a = addr; req_data_a = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!tgt_valid && !ack_o && lat < 50);

    n_checks++;
    if (lat !== S + 1) begin
      n_fail++; $display("FAIL %s start_latency: got %0d exp %0d", tag, lat, S + 1);
    end
    n_checks++;
    if (tgt_valid !== is_rw) begin
      n_fail++; $display("FAIL %s tgt_valid_on_start: got %b exp %b", tag, tgt_valid, is_rw);
    end

    if (is_rw) begin
      n_checks++;
      if (tgt_addr !== addr || tgt_write !== (op == 2'd2) || tgt_wdata !== wdata) begin
        n_fail++;
        $display("FAIL %s tgt_payload: got a=%h w=%b d=%h exp a=%h w=%b d=%h",
                 tag, tgt_addr, tgt_write, tgt_wdata, addr, (op == 2'd2), wdata);
      end
      n = 0; vcount = 0; aborts = 0;
      while (!ack_o && n < 100) begin
        if (tgt_valid) vcount++;
        if (tgt_abort) aborts++;
        tgt_ready     = (n == dr);
        tgt_rsp_valid = (n == dr + ds) || (spur && n == dr);
        tgt_rsp_data  = (n == dr + ds) ? rdata : DATA_W'($urandom);
        tgt_rsp_err   = (n == dr + ds) ? err : 1'($urandom);
        if (n == drop_n) req_a = 1'b0;
        @(negedge clk);
        n++;
      end
      idle_target();
      n_checks++;
      if (n !== c) begin
        n_fail++; $display("FAIL %s ack_latency: got %0d exp %0d", tag, n, c);
      end
      n_checks++;
      if (vcount !== ((dr + 1 < c) ? dr + 1 : c)) begin
        n_fail++; $display("FAIL %s tgt_valid_cycles: got %0d exp %0d", tag, vcount,
                           (dr + 1 < c) ? dr + 1 : c);
      end
      n_checks++;
      if (aborts !== 0 || tgt_abort !== exp_tmo) begin
        n_fail++; $display("FAIL %s tgt_abort: early=%0d at_ack=%b exp_at_ack=%b",
                           tag, aborts, tgt_abort, exp_tmo);
      end
    end

    n_checks++;
    if (ack_o !== 1'b1 || busy !== 1'b1 || rsp_status_o !== exp_st || rsp_data_o !== exp_d) begin
      n_fail++;
      $display("FAIL %s response: got ack=%b busy=%b st=%0d d=%h exp ack=1 busy=1 st=%0d d=%h",
               tag, ack_o, busy, rsp_status_o, rsp_data_o, exp_st, exp_d);
    end

    rel = 0;
    if (req_a) begin
      req_a = 1'b0;
      do begin
        @(negedge clk);
        rel++;
        if (tgt_abort) aborts++;
      end while (ack_o && rel < 50);
      n_checks++;
      if (rel !== S + 1) begin
        n_fail++; $display("FAIL %s ack_release_latency: got %0d exp %0d", tag, rel, S + 1);
      end
    end else begin
      while (ack_o && rel < 50) begin
        @(negedge clk);
        rel++;
      end
      n_checks++;
      if (ack_o !== 1'b0) begin
        n_fail++; $display("FAIL %s ack_release_early_drop: got %b exp 0", tag, ack_o);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || tgt_valid !== 1'b0 || rsp_data_o !== exp_d || proto_err !== m_proto) begin
      n_fail++;
      $display("FAIL %s after_release: got busy=%b vld=%b d=%h perr=%b exp busy=0 vld=0 d=%h perr=%b",
               tag, busy, tgt_valid, rsp_data_o, proto_err, exp_d, m_proto);
    end
    if (is_rw) begin
      n_checks++;
      if (aborts !== 0) begin
        n_fail++; $display("FAIL %s abort_width: extra pulses %0d exp 0", tag, aborts);
      end
    end
    m_rsp_data = exp_d;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_a = 1'b0; req_op_a = '0; req_addr_a = '0; req_data_a = '0;
    idle_target();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack_o !== 1'b0 || tgt_valid !== 1'b0 || tgt_abort !== 1'b0 || busy !== 1'b0 ||
        proto_err !== 1'b0 || rsp_data_o !== '0 || rsp_status_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ack=%b vld=%b abt=%b busy=%b perr=%b d=%h st=%0d exp all 0",
               ack_o, tgt_valid, tgt_abort, busy, proto_err, rsp_data_o, rsp_status_o);
    end
    m_rsp_data = '0; m_proto = 1'b0;
  endtask

  task automatic test_read();
    run_txn(2'd1, 7'h11, 32'h0, 2, 1, 1'b0, 32'hDEADBEEF, 1'b0, -1, "read");
  endtask

  task automatic test_write_err();
    run_txn(2'd2, 7'h10, 32'h1, 0, 2, 1'b1, 32'hCAFEF00D, 1'b0, -1, "write_err");
  endtask

  task automatic test_timeout();
    run_txn(2'd1, 7'h22, 32'h0, 20, 1, 1'b0, 32'h12345678, 1'b0, -1, "timeout");
    run_txn(2'd1, 7'h23, 32'h0, 1, 1, 1'b0, 32'h0BADF00D, 1'b0, -1, "read_after_timeout");
    run_txn(2'd2, 7'h24, 32'h55AA55AA, 3, 5, 1'b0, 32'h0, 1'b0, -1, "timeout_in_wait");
    run_txn(2'd1, 7'h25, 32'h0, 3, 4, 1'b0, 32'h600DD00D, 1'b0, -1, "rsp_on_timeout_edge");
  endtask

  task automatic test_nop_reserved();
    run_txn(2'd0, 7'h05, 32'hFFFF0000, 0, 1, 1'b0, 32'h0, 1'b0, -1, "nop");
    run_txn(2'd3, 7'h06, 32'h0000FFFF, 0, 1, 1'b0, 32'h0, 1'b0, -1, "reserved");
  endtask

  task automatic test_random();
    int dr;
    for (int i = 0; i < 30; i++) begin
      dr = ($urandom_range(0, 4) == 0) ? 20 : int'($urandom_range(0, T - 2));
      run_txn(2'($urandom_range(0, 3)), 7'($urandom), 32'($urandom), dr,
              int'($urandom_range(1, 6)), 1'($urandom), 32'($urandom),
              1'($urandom), -1, "random");
    end
  endtask

  task automatic test_proto_violation();
    run_txn(2'd1, 7'h33, 32'h0, 1, 6, 1'b0, 32'hA5A5A5A5, 1'b0, 2, "proto_drop");
    run_txn(2'd2, 7'h34, 32'h77, 0, 1, 1'b0, 32'h0, 1'b0, -1, "proto_sticky");
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    req_a = 1'b1; req_op_a = 2'd1; req_addr_a = 7'h44; req_data_a = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!tgt_valid && lat < 50);
    tgt_ready = 1'b1;
    @(negedge clk);
    tgt_ready = 1'b0;
    n_checks++;
    if (tgt_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_in_wait: got vld=%b busy=%b exp vld=0 busy=1",
                         tgt_valid, busy);
    end
    reset = 1'b1; req_a = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (tgt_valid !== 1'b0 || ack_o !== 1'b0 || busy !== 1'b0 || proto_err !== 1'b0 ||
        rsp_status_o !== 2'd0 || rsp_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_state: got vld=%b ack=%b busy=%b perr=%b st=%0d d=%h exp all 0",
               tgt_valid, ack_o, busy, proto_err, rsp_status_o, rsp_data_o);
    end
    tgt_rsp_valid = 1'b1; tgt_rsp_data = 32'hBAADBAAD; tgt_rsp_err = 1'b1;
    @(negedge clk);
    idle_target();
    @(negedge clk);
    n_checks++;
    if (ack_o !== 1'b0 || busy !== 1'b0 || rsp_status_o !== 2'd0 || rsp_data_o !== '0) begin
      n_fail++;
      $display("FAIL late_rsp_ignored: got ack=%b busy=%b st=%0d d=%h exp 0 0 0 0",
               ack_o, busy, rsp_status_o, rsp_data_o);
    end
    m_rsp_data = '0; m_proto = 1'b0;
    run_txn(2'd1, 7'h45, 32'h0, 1, 2, 1'b0, 32'h13579BDF, 1'b0, -1, "read_after_reset");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_err();
    test_timeout();
    test_nop_reserved();
    test_random();
    test_proto_violation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
